// File: rtl/fft_inplace_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIT FFT.
// Issues read pairs and twiddle indices; replays writes after the butterfly latency.
module fft_inplace_sequencer #(
    parameter  int N_POINT    = 16,
    parameter  int BF_LATENCY = 2,
    localparam int LOG2N      = $clog2(N_POINT),
    localparam int SW         = $clog2(LOG2N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [SW-1:0]    stage
);

    localparam int KW  = LOG2N - 1;
    localparam int DW  = $clog2(BF_LATENCY + 1);
    localparam int DLW = 2 * LOG2N + 1;

    localparam logic [KW-1:0] K_LAST = KW'(N_POINT / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_n;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_s_n;
    logic [DW-1:0]   r_dcnt;
    logic [DW-1:0]   w_dcnt_n;

    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [LOG2N-2:0] r_tw;
    logic [SW-1:0]    r_stage;
    logic [DLW-1:0]   r_dly [BF_LATENCY];

    logic             w_issue;
    logic             w_busy_n;
    logic [LOG2N-1:0] w_kx;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_j;
    logic [LOG2N-1:0] w_a;
    logic [LOG2N-1:0] w_b;
    logic [LOG2N-2:0] w_tw;
    logic [SW-1:0]    w_s1;
    logic [SW-1:0]    w_sht;

    always_comb begin
        w_state_n = r_state;
        w_k_n     = r_k;
        w_s_n     = r_s;
        w_dcnt_n  = r_dcnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_ISSUE;
                    w_k_n     = '0;
                    w_s_n     = '0;
                end
            end
            S_ISSUE: begin
                if (r_k == K_LAST) begin
                    w_state_n = S_DRAIN;
                    w_dcnt_n  = '0;
                end else begin
                    w_k_n = r_k + KW'(1);
                end
            end
            S_DRAIN: begin
                if (r_dcnt != D_LAST) begin
                    w_dcnt_n = r_dcnt + DW'(1);
                end else if (r_s == S_LAST) begin
                    w_state_n = S_DONE;
                end else begin
                    w_state_n = S_ISSUE;
                    w_s_n     = r_s + SW'(1);
                    w_k_n     = '0;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_s_n     = '0;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Addresses are derived from next-state counters so the outputs can be registered.
    always_comb begin
        w_issue  = (w_state_n == S_ISSUE);
        w_busy_n = (w_state_n == S_ISSUE) || (w_state_n == S_DRAIN);
        w_kx     = {1'b0, w_k_n};
        w_half   = LOG2N'(1) << w_s_n;
        w_j      = w_kx & (w_half - LOG2N'(1));
        w_s1     = w_s_n + SW'(1);
        w_sht    = S_LAST - w_s_n;
        w_a      = ((w_kx >> w_s_n) << w_s1) | w_j;
        w_b      = w_a | w_half;
        w_tw     = w_j[LOG2N-2:0] << w_sht;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_stage <= '0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_k     <= w_k_n;
            r_s     <= w_s_n;
            r_dcnt  <= w_dcnt_n;
            r_busy  <= w_busy_n;
            r_done  <= (w_state_n == S_DONE);
            r_rd_en <= w_issue;
            r_rd_a  <= w_issue ? w_a : '0;
            r_rd_b  <= w_issue ? w_b : '0;
            r_tw    <= w_issue ? w_tw : '0;
            r_stage <= w_busy_n ? w_s_n : '0;
            r_dly[0] <= {r_rd_en, r_rd_a, r_rd_b};
            for (int i = 1; i < BF_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_idx    = r_tw;
    assign stage     = r_stage;
    assign {wr_en, wr_addr_a, wr_addr_b} = r_dly[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_inplace_sequencer.sv
// Directed bench for fft_inplace_sequencer: N=16/L=2 main instance
// plus an N=8/L=1 instance for the alternate configuration.
module tb_fft_inplace_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start8;

    logic       busy, done, rd_en, wr_en;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_idx;
    logic [2:0] stage;

    logic       busy8, done8, rd_en8, wr_en8;
    logic [2:0] rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8;
    logic [1:0] tw_idx8;
    logic [2:0] stage8;

    int n_cmp = 0;
    int n_bad = 0;

    int A16 [4][8] = '{'{0, 2, 4, 6, 8, 10, 12, 14},
                       '{0, 1, 4, 5, 8, 9, 12, 13},
                       '{0, 1, 2, 3, 8, 9, 10, 11},
                       '{0, 1, 2, 3, 4, 5, 6, 7}};
    int B16 [4][8] = '{'{1, 3, 5, 7, 9, 11, 13, 15},
                       '{2, 3, 6, 7, 10, 11, 14, 15},
                       '{4, 5, 6, 7, 12, 13, 14, 15},
                       '{8, 9, 10, 11, 12, 13, 14, 15}};
    int T16 [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                       '{0, 4, 0, 4, 0, 4, 0, 4},
                       '{0, 2, 4, 6, 0, 2, 4, 6},
                       '{0, 1, 2, 3, 4, 5, 6, 7}};

    int A8 [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int B8 [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int T8 [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    always #5 clk = ~clk;

    fft_inplace_sequencer #(.N_POINT(16), .BF_LATENCY(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    fft_inplace_sequencer #(.N_POINT(8), .BF_LATENCY(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .busy      (busy8),
        .done      (done8),
        .rd_en     (rd_en8),
        .rd_addr_a (rd_addr_a8),
        .rd_addr_b (rd_addr_b8),
        .tw_idx    (tw_idx8),
        .wr_en     (wr_en8),
        .wr_addr_a (wr_addr_a8),
        .wr_addr_b (wr_addr_b8),
        .stage     (stage8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {rd_en, a, b, tw} expected in cycle c of an N=16 run (start sampled at edge 0)
    function automatic logic [11:0] rd16(input int c);
        int st;
        int k;
        if (c < 1 || c > 40) return '0;
        st = (c - 1) / 10;
        k  = (c - 1) % 10;
        if (k >= 8) return '0;
        return {1'b1, 4'(A16[st][k]), 4'(B16[st][k]), 3'(T16[st][k])};
    endfunction

    function automatic logic [8:0] rd8(input int c);
        int st;
        int k;
        if (c < 1 || c > 15) return '0;
        st = (c - 1) / 5;
        k  = (c - 1) % 5;
        if (k >= 4) return '0;
        return {1'b1, 3'(A8[st][k]), 3'(B8[st][k]), 2'(T8[st][k])};
    endfunction

    task automatic zero16(input string tag);
        chk(tag, {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                  wr_en, wr_addr_a, wr_addr_b, stage}, 32'd0);
    endtask

    task automatic check16(input int c);
        logic [11:0] e;
        logic [11:0] w;
        int          est;
        e   = rd16(c);
        w   = rd16(c - 2);
        est = (c <= 40) ? (c - 1) / 10 : 0;
        chk($sformatf("busy@%0d", c), busy, (c <= 40));
        chk($sformatf("done@%0d", c), done, (c == 41));
        chk($sformatf("stage@%0d", c), stage, est);
        chk($sformatf("rd@%0d", c), {rd_en, rd_addr_a, rd_addr_b, tw_idx}, e);
        chk($sformatf("wr@%0d", c), {wr_en, wr_addr_a, wr_addr_b}, w[11:3]);
    endtask

    // Start is raised in the current cycle; checks cycles 1..last_c.
    task automatic run16(input int pulse_c, input int last_c, input bit rst_last);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            check16(c);
            start = (c == pulse_c);
            rst   = rst_last && (c == last_c);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        start8 = 1'b0;
        step();
        zero16("rst_c0");
        step();
        zero16("rst_c1");
        chk("rst8", {busy8, done8, rd_en8, wr_en8, stage8}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        zero16("post_rst");

        run16(20, 41, 1'b0);
        zero16("idle_42");
        run16(-1, 41, 1'b0);
        run16(-1, 15, 1'b1);
        zero16("midrst_16");
        step();
        zero16("midrst_17");
        step();
        zero16("midrst_18");
        run16(-1, 41, 1'b0);

        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            logic [8:0] e;
            logic [8:0] w;
            e = rd8(c);
            w = rd8(c - 1);
            chk($sformatf("busy8@%0d", c), busy8, (c <= 15));
            chk($sformatf("done8@%0d", c), done8, (c == 16));
            chk($sformatf("stage8@%0d", c), stage8, (c <= 15) ? (c - 1) / 5 : 0);
            chk($sformatf("rd8@%0d", c), {rd_en8, rd_addr_a8, rd_addr_b8, tw_idx8}, e);
            chk($sformatf("wr8@%0d", c), {wr_en8, wr_addr_a8, wr_addr_b8}, w[8:2]);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
